// File: rtl/mul_share_ctrl.sv
// Two-requester sequencer for a shared 3-product 16x16 multiplier cell.
// Produces the low or high word of a 32x32 unsigned product.
module mul_share_ctrl #(
   parameter int TAG_W    = 4,
   parameter int CELL_LAT = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [1:0]         req_op,
   input  logic [63:0]        req_a,
   input  logic [63:0]        req_b,
   input  logic [2*TAG_W-1:0] req_tag,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_id,
   output logic [TAG_W-1:0]   rsp_tag,
   output logic [31:0]        rsp_data,
   output logic [31:0]        cell_src1,
   output logic [31:0]        cell_src2,
   output logic               cell_en,
   input  logic [31:0]        cell_p1,
   input  logic [31:0]        cell_p2,
   input  logic [31:0]        cell_p3
);

   typedef enum logic [2:0] {
      IDLE, ISS1, WAIT1, CAP1, ISS2, WAIT2, CAP2, RESP
   } state_t;

   localparam int CW = 8;
   localparam logic [CW-1:0] WLOAD = CW'(CELL_LAT > 1 ? CELL_LAT - 2 : 0);

   state_t           state_q, state_d;
   logic [CW-1:0]    wcnt_q, wcnt_d;
   logic             ptr_q, ptr_d;
   logic             id_q, id_d;
   logic             op_q, op_d;
   logic [15:0]      ah_q, ah_d;
   logic [15:0]      bh_q, bh_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [16:0]      acch_q, acch_d;
   logic [31:0]      data_q, data_d;
   logic [31:0]      src1_q, src1_d;
   logic [31:0]      src2_q, src2_d;
   logic             en_q, en_d;

   logic             any_v;
   logic             gnt;
   logic [31:0]      sel_a;
   logic [31:0]      sel_b;
   logic [TAG_W-1:0] sel_tag;
   logic             sel_op;
   logic [32:0]      mid;
   logic [48:0]      acc1;
   logic [31:0]      hi;

   assign any_v   = |req_valid;
   assign gnt     = req_valid[ptr_q] ? ptr_q : ~ptr_q;
   // Ternary selects keep X on the losing requester's operands out of the datapath
   assign sel_a   = gnt ? req_a[63:32] : req_a[31:0];
   assign sel_b   = gnt ? req_b[63:32] : req_b[31:0];
   assign sel_tag = gnt ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
   assign sel_op  = gnt ? req_op[1] : req_op[0];

   // Cross terms are summed 33 bits wide; the carry reaches bit 48 for large operands
   assign mid  = {1'b0, cell_p2} + {1'b0, cell_p3};
   assign acc1 = {17'b0, cell_p1} + {mid, 16'b0};
   assign hi   = {15'b0, acch_q} + cell_p1;

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      ptr_d     = ptr_q;
      id_d      = id_q;
      op_d      = op_q;
      ah_d      = ah_q;
      bh_d      = bh_q;
      tag_d     = tag_q;
      acch_d    = acch_q;
      data_d    = data_q;
      src1_d    = src1_q;
      src2_d    = src2_q;
      en_d      = 1'b0;
      req_ready = 2'b00;
      unique case (state_q)
         IDLE: begin
            if (any_v) begin
               req_ready = gnt ? 2'b10 : 2'b01;
               id_d      = gnt;
               ptr_d     = ~gnt;
               op_d      = sel_op;
               tag_d     = sel_tag;
               ah_d      = sel_a[31:16];
               bh_d      = sel_b[31:16];
               src1_d    = sel_a;
               src2_d    = sel_b;
               en_d      = 1'b1;
               state_d   = ISS1;
            end
         end
         ISS1: begin
            wcnt_d  = WLOAD;
            state_d = (CELL_LAT > 1) ? WAIT1 : CAP1;
         end
         WAIT1: begin
            if (wcnt_q == '0) state_d = CAP1;
            else wcnt_d = wcnt_q - CW'(1);
         end
         CAP1: begin
            acch_d = acc1[48:32];
            if (op_q) begin
               src1_d  = {16'h0, ah_q};
               src2_d  = {16'h0, bh_q};
               en_d    = 1'b1;
               state_d = ISS2;
            end else begin
               data_d  = acc1[31:0];
               state_d = RESP;
            end
         end
         ISS2: begin
            wcnt_d  = WLOAD;
            state_d = (CELL_LAT > 1) ? WAIT2 : CAP2;
         end
         WAIT2: begin
            if (wcnt_q == '0) state_d = CAP2;
            else wcnt_d = wcnt_q - CW'(1);
         end
         CAP2: begin
            data_d  = hi;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         ptr_q   <= 1'b0;
         id_q    <= 1'b0;
         op_q    <= 1'b0;
         ah_q    <= '0;
         bh_q    <= '0;
         tag_q   <= '0;
         acch_q  <= '0;
         data_q  <= '0;
         src1_q  <= '0;
         src2_q  <= '0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         op_q    <= op_d;
         ah_q    <= ah_d;
         bh_q    <= bh_d;
         tag_q   <= tag_d;
         acch_q  <= acch_d;
         data_q  <= data_d;
         src1_q  <= src1_d;
         src2_q  <= src2_d;
         en_q    <= en_d;
      end
   end

   assign rsp_valid = (state_q == RESP);
   assign rsp_id    = id_q;
   assign rsp_tag   = tag_q;
   assign rsp_data  = data_q;
   assign cell_src1 = src1_q;
   assign cell_src2 = src2_q;
   assign cell_en   = en_q;

endmodule
